// File: rtl/ring_credit_net.sv
// ring_credit_net: unidirectional ring of NUM_NODES routers with credit-based
// hop flow control. Node i forwards to node (i+1) mod NUM_NODES through a
// BUF_DEPTH input FIFO at the receiver. Each node has a valid/ready injection
// port and an ejection port to its core. Injection keeps one downstream slot
// in reserve for ring traffic (bubble rule), and a per-node starvation counter
// lets a blocked injection eventually win its link over forwarded flits.

module ring_credit_net #(
    parameter int NUM_NODES    = 4,
    parameter int DATA_W       = 128,
    parameter int ID_W         = 8,
    parameter int BUF_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic [NUM_NODES-1:0]        inj_valid,
    input  logic [NUM_NODES*ID_W-1:0]   inj_dest,
    input  logic [NUM_NODES*DATA_W-1:0] inj_data,
    output logic [NUM_NODES-1:0]        inj_ready,
    output logic [NUM_NODES-1:0]        ej_valid,
    output logic [NUM_NODES*ID_W-1:0]   ej_src,
    output logic [NUM_NODES*DATA_W-1:0] ej_data,
    input  logic [NUM_NODES-1:0]        ej_ready,
    output logic [NUM_NODES-1:0]        err_drop
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] INJ_MIN_C = CNT_W'(2);
    localparam logic [ST_W-1:0]  STARVE_C  = ST_W'(STARVE_LIMIT);
    localparam logic [ID_W:0]    NODES_C   = (ID_W + 1)'(NUM_NODES);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    typedef struct packed {
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   dest;
        logic [DATA_W-1:0] data;
    } flit_t;

    // Ring input FIFO storage and bookkeeping, one per node.
    flit_t            mem_q    [NUM_NODES][BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_NODES];
    logic [PTR_W-1:0] rd_ptr_d [NUM_NODES];
    logic [PTR_W-1:0] wr_ptr_q [NUM_NODES];
    logic [PTR_W-1:0] wr_ptr_d [NUM_NODES];
    logic [CNT_W-1:0] count_q  [NUM_NODES];
    logic [CNT_W-1:0] count_d  [NUM_NODES];

    // credit_q[i] counts free slots node i may still claim in FIFO[i+1].
    logic [CNT_W-1:0] credit_q [NUM_NODES];
    logic [CNT_W-1:0] credit_d [NUM_NODES];
    logic [ST_W-1:0]  starve_q [NUM_NODES];
    logic [ST_W-1:0]  starve_d [NUM_NODES];

    // ret_q[j]: node j popped last cycle, so node j-1 gets its credit back.
    logic [NUM_NODES-1:0] ret_q, ret_d;
    logic [NUM_NODES-1:0] err_q, err_d;

    // Per-node combinational decisions.
    flit_t                head      [NUM_NODES];
    flit_t                link_flit [NUM_NODES];
    flit_t                wr_flit   [NUM_NODES];
    logic [ID_W-1:0]      dest_w    [NUM_NODES];
    logic [NUM_NODES-1:0] head_vld, local_hit, fwd_req, dest_ok, starved;
    logic [NUM_NODES-1:0] inj_ok, inj_fire, fwd_fire, ej_fire, pop, send;
    logic [NUM_NODES-1:0] wr_en, ret_in;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Link arbitration, ejection, and next-state for every node.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves a value held over from the previous evaluation (no latches).
        head      = '{default: '0};
        link_flit = '{default: '0};
        wr_flit   = '{default: '0};
        dest_w    = '{default: '0};
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        credit_d  = credit_q;
        starve_d  = starve_q;
        head_vld  = '0;
        local_hit = '0;
        fwd_req   = '0;
        dest_ok   = '0;
        starved   = '0;
        inj_ok    = '0;
        inj_fire  = '0;
        fwd_fire  = '0;
        ej_fire   = '0;
        pop       = '0;
        send      = '0;
        wr_en     = '0;
        ret_in    = '0;
        ej_valid  = '0;
        ej_src    = '0;
        ej_data   = '0;
        inj_ready = '0;

        for (int i = 0; i < NUM_NODES; i++) begin
            head[i]      = mem_q[i][rd_ptr_q[i]];
            head_vld[i]  = (count_q[i] != '0);
            local_hit[i] = (head[i].dest == ID_W'(i));
            ej_valid[i]  = head_vld[i] && local_hit[i];
            ej_src[i*ID_W +: ID_W]     = head[i].src;
            ej_data[i*DATA_W +: DATA_W] = head[i].data;
            fwd_req[i]   = head_vld[i] && !local_hit[i];

            dest_w[i]    = inj_dest[i*ID_W +: ID_W];
            dest_ok[i]   = ({1'b0, dest_w[i]} < NODES_C);
            starved[i]   = (starve_q[i] == STARVE_C);

            // Injection keeps one slot downstream free for ring traffic, and
            // yields to a forward request unless the node is starved.
            inj_ok[i]    = (credit_q[i] >= INJ_MIN_C) && (starved[i] || !fwd_req[i]);
            inj_ready[i] = !dest_ok[i] || inj_ok[i];
            inj_fire[i]  = inj_valid[i] && dest_ok[i] && inj_ok[i];
            fwd_fire[i]  = fwd_req[i] && (credit_q[i] != '0) && !inj_fire[i];
            ej_fire[i]   = ej_valid[i] && ej_ready[i];
            pop[i]       = ej_fire[i] || fwd_fire[i];
            send[i]      = inj_fire[i] || fwd_fire[i];
            link_flit[i] = inj_fire[i] ? flit_t'{ID_W'(i), dest_w[i], inj_data[i*DATA_W +: DATA_W]}
                                       : head[i];

            if (!inj_valid[i] || inj_ready[i]) begin
                starve_d[i] = '0;
            end else if (!starved[i]) begin
                starve_d[i] = starve_q[i] + ST_W'(1);
            end
        end

        for (int i = 0; i < NUM_NODES; i++) begin
            wr_en[i]   = send[(i + NUM_NODES - 1) % NUM_NODES];
            wr_flit[i] = link_flit[(i + NUM_NODES - 1) % NUM_NODES];
            ret_in[i]  = ret_q[(i + 1) % NUM_NODES];

            if (pop[i])   rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            if (wr_en[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);

            case ({wr_en[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase

            // A send and a returned credit in the same cycle cancel out.
            case ({send[i], ret_in[i]})
                2'b10:   credit_d[i] = credit_q[i] - CNT_W'(1);
                2'b01:   credit_d[i] = credit_q[i] + CNT_W'(1);
                default: credit_d[i] = credit_q[i];
            endcase
        end

        ret_d = pop;
        err_d = inj_valid & ~dest_ok;
    end

    // Control state: pointers, occupancy, credits, starvation, pulses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (!rst_l) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                credit_q[i] <= DEPTH_C;
                starve_q[i] <= '0;
            end
            ret_q <= '0;
            err_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
            starve_q <= starve_d;
            ret_q    <= ret_d;
            err_q    <= err_d;
        end
    end

    // FIFO payload storage, written by the upstream link.
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately not reset; occupancy and
        // pointers are, so stale entries are never read out.
        for (int i = 0; i < NUM_NODES; i++) begin
            if (wr_en[i]) mem_q[i][wr_ptr_q[i]] <= wr_flit[i];
        end
    end

    assign err_drop = err_q;

    // Credit accounting must make FIFO overflow impossible.
    for (genvar g = 0; g < NUM_NODES; g++) begin : g_chk
        a_no_overflow : assert property (@(posedge clk) disable iff (!rst_l)
            !(wr_en[g] && (count_q[g] == DEPTH_C)));
        a_credit_max : assert property (@(posedge clk) disable iff (!rst_l)
            credit_q[g] <= DEPTH_C);
        a_credit_min : assert property (@(posedge clk) disable iff (!rst_l)
            !(send[g] && (credit_q[g] == '0)));
    end

endmodule
